// File: rtl/pattern_event_logger.sv
// pattern_event_logger: measures contiguous det_in bursts and queues one
// {length, start timestamp} record per burst in a first-word-fall-through FIFO.
// Also keeps a saturating completed-burst counter and a sticky drop flag.
// Optional macro PATTERN_LOG_TIMESTAMP_EN adds a free-running timestamp that is
// captured at burst start; without it rec_ts is constant 0.
module pattern_event_logger #(
    parameter int LEN_W = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16,
    parameter int TS_W  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       det_in,
    input  logic                       clr_stats,
    output logic                       rec_valid,
    input  logic                       rec_ready,
    output logic [LEN_W-1:0]           rec_len,
    output logic [TS_W-1:0]            rec_ts,
    output logic [CNT_W-1:0]           evt_count,
    output logic [$clog2(DEPTH):0]     fill,
    output logic                       overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int FW = PW + 1;
    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_next;
    logic [LEN_W-1:0] run_len, run_len_next;
    logic             complete;
    logic             pop, full, push, drop;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [LEN_W-1:0] len_mem [DEPTH];

    // Burst tracker: next state, run length and completion strobe
    always_comb begin
        state_next   = state;
        run_len_next = run_len;
        complete     = 1'b0;
        case (state)
            IDLE: begin
                if (det_in) begin
                    state_next   = RUN;
                    run_len_next = LEN_W'(1);
                end
            end
            RUN: begin
                if (det_in) begin
                    if (run_len != LEN_MAX)
                        run_len_next = run_len + 1'b1;
                end else begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Burst tracker state register; reset drops any burst in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            run_len <= '0;
        end else begin
            state   <= state_next;
            run_len <= run_len_next;
        end
    end

    // A completion into a full FIFO still lands if the head leaves the same cycle
    assign rec_valid = (fill != '0);
    assign pop       = rec_valid & rec_ready;
    assign full      = (fill == FW'(DEPTH));
    assign push      = complete & (~full | pop);
    assign drop      = complete & full & ~pop;

    // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is a power of 2)
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    // Length storage; cleared on reset so the empty head reads 0
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) len_mem[i] <= '0;
        end else if (push) begin
            len_mem[wr_ptr] <= run_len;
        end
    end

    assign rec_len = len_mem[rd_ptr];

`ifdef PATTERN_LOG_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt, start_ts;
    logic [TS_W-1:0] ts_mem [DEPTH];

    // Free-running timestamp, latched on the IDLE->RUN cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            ts_cnt   <= '0;
            start_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            if (state == IDLE && det_in) start_ts <= ts_cnt;
        end
    end

    // Timestamp storage alongside the length field
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) ts_mem[i] <= '0;
        end else if (push) begin
            ts_mem[wr_ptr] <= start_ts;
        end
    end

    assign rec_ts = ts_mem[rd_ptr];
`else
    assign rec_ts = '0;
`endif

    // Statistics: clear beats a same-cycle completion or drop
    always_ff @(posedge clk) begin
        if (reset) begin
            evt_count <= '0;
            overflow  <= 1'b0;
        end else if (clr_stats) begin
            evt_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (complete && evt_count != CNT_MAX) evt_count <= evt_count + 1'b1;
            if (drop) overflow <= 1'b1;
        end
    end
endmodule

// File: doc/pattern_event_logger.md
Name: pattern_event_logger

Overview:
- Downstream consumer of the run-of-ones pattern detector's registered output q.
- Measures each contiguous detection burst (det_in high) in cycles and queues one record per burst in a small first-word-fall-through FIFO.
- Software/host logic drains the FIFO over a valid/ready handshake.
- Keeps a saturating burst counter and a sticky overflow flag.

Parameters:
- LEN_W, 8: width of burst-length field; length saturates at 2^LEN_W-1.
- DEPTH, 4: record FIFO depth, power of 2, minimum 2.
- CNT_W, 16: width of total burst counter; saturates at all-ones.
- TS_W, 16: width of start-timestamp field (used only with the optional feature).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- det_in  in  1  detector output q, one sample per cycle.
- clr_stats  in  1  clears evt_count and overflow.
- rec_valid  out  1  FIFO head holds a record.
- rec_ready  in  1  consumer accepts head when rec_valid=1.
- rec_len  out  LEN_W  burst length of head record.
- rec_ts  out  TS_W  start timestamp of head record.
- evt_count  out  CNT_W  number of completed bursts since reset/clear.
- fill  out  $clog2(DEPTH)+1  records currently stored.
- overflow  out  1  sticky: a completed burst was dropped.

Behaviour:
- Reset: rec_valid=0, fill=0, evt_count=0, overflow=0, rec_len=0, rec_ts=0. FSM->IDLE, run_len=0, FIFO pointers=0.
- Reset mid-burst discards the burst with no record and no count. Reset empties the FIFO.
- FSM, states IDLE and RUN:
  - IDLE, det_in=1: go to RUN, run_len<=1, capture start timestamp.
  - IDLE, det_in=0: stay in IDLE.
  - RUN, det_in=1: run_len<=run_len+1, saturating at 2^LEN_W-1.
  - RUN, det_in=0: complete the burst, push {run_len, start_ts}, go to IDLE.
- A single-cycle pulse yields rec_len=1. Back-to-back bursts separated by one low cycle produce two records.
- Latency: if the first det_in=0 is sampled at edge N, the record is in the FIFO and rec_valid=1 after edge N (visible in cycle N+1), provided the FIFO was not full.
- FIFO is first-word fall-through: rec_len/rec_ts always show the head. When empty, the outputs hold their last value (don't care).
- Pop occurs on an edge where rec_valid=1 and rec_ready=1. rec_ready with rec_valid=0 is ignored.
- Push when full with no pop in the same cycle: record dropped, overflow<=1, fill unchanged.
- Push when full with a pop in the same cycle: both happen, no drop, fill stays DEPTH.
- Push and pop together at any other fill: fill unchanged.
- Pointers wrap modulo DEPTH. fill ranges 0..DEPTH.
- evt_count increments on every burst completion, whether the record is stored or dropped, and saturates at 2^CNT_W-1.
- clr_stats=1: evt_count<=0, overflow<=0. Clear has priority over a same-cycle completion or overflow, so that event is not counted or flagged.
- clr_stats does not affect the FSM, FIFO, or fill.

Optional Feature:
- PATTERN_LOG_TIMESTAMP_EN defined:
  - A free-running TS_W counter is cleared by reset, increments every cycle, and wraps to 0.
  - The counter value in the IDLE->RUN cycle is stored with the record and appears on rec_ts.
- Not defined: no timestamp counter or storage; rec_ts is constant 0.

Test Plan:
- Reset, then det_in high for 3 cycles, then low -> one record rec_len=3, rec_valid=1 one cycle after the first low sample, evt_count=1, fill=1.
- rec_ready held 0; five 2-cycle bursts with DEPTH=4 -> fill=4, overflow=1, evt_count=5; draining returns rec_len=2 four times, then rec_valid=0.
- FIFO full and a burst completes in the same cycle as a pop -> no overflow, fill stays 4, the new record is read last.
- det_in high for 300 cycles with LEN_W=8 -> rec_len=255. Also reset asserted in the middle of a 10-cycle burst -> no record, evt_count=0.
- evt_count=7, overflow=1, then clr_stats in the same cycle as a burst completion -> evt_count=0, overflow=0; the record is still pushed.
- With PATTERN_LOG_TIMESTAMP_EN: burst starting 20 cycles after reset release -> rec_ts=20. Without the macro -> rec_ts=0.
